// File: rtl/farrow_pkg.sv
// farrow_pkg: shared types and limits for the polynomial evaluation sequencers.
package farrow_pkg;
  localparam int N_MAX = 16;
  localparam int K_W = $clog2(N_MAX);
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_ADD,
    S_WAIT_ADD,
    S_ISSUE_MUL,
    S_WAIT_MUL,
    S_OUT
  } hs_state_t;
endpackage

// File: rtl/horner_sequencer.sv
// horner_sequencer: Horner polynomial evaluation driving shared external add/multiply units.
module horner_sequencer
  import farrow_pkg::*;
#(
  parameter int BITS = 16,
  parameter string PRECISION = "HALF",
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] coef_in [N],
  input  logic [BITS-1:0] xin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] yout,
  output logic            add_valid,
  output logic [BITS-1:0] add_a,
  output logic [BITS-1:0] add_b,
  input  logic            add_done,
  input  logic [BITS-1:0] add_c,
  output logic            mul_valid,
  output logic [BITS-1:0] mul_a,
  output logic [BITS-1:0] mul_b,
  input  logic            mul_done,
  input  logic [BITS-1:0] mul_c
);
  if (N < 1 || N > N_MAX || PRECISION == "") begin : g_bad_cfg
    $error("horner_sequencer: unsupported configuration");
  end
  hs_state_t       r_state;
  logic [BITS-1:0] r_c [N];
  logic [BITS-1:0] r_x;
  logic [BITS-1:0] r_acc;
  logic [BITS-1:0] r_y;
  logic [K_W-1:0]  r_k;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_add_valid;
  logic            r_mul_valid;
  // Coefficients shift up after each multiply, so the next one is always at the top.
  assign add_a     = r_c[N-1];
  assign add_b     = r_acc;
  assign mul_a     = r_acc;
  assign mul_b     = r_x;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign yout      = r_y;
  assign add_valid = r_add_valid;
  assign mul_valid = r_mul_valid;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_c         <= '{default: '0};
      r_x         <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_add_valid <= 1'b0;
      r_mul_valid <= 1'b0;
    end else begin
      r_add_valid <= 1'b0;
      r_mul_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_c         <= coef_in;
            r_x         <= xin;
            r_acc       <= '0;
            r_k         <= K_W'(N - 1);
            r_in_ready  <= 1'b0;
            r_add_valid <= 1'b1;
            r_state     <= S_ISSUE_ADD;
          end
        end
        S_ISSUE_ADD: r_state <= S_WAIT_ADD;
        S_WAIT_ADD: begin
          if (add_done) begin
            r_acc <= add_c;
            if (r_k != '0) begin
              r_mul_valid <= 1'b1;
              r_state     <= S_ISSUE_MUL;
            end else begin
              r_y         <= add_c;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end
          end
        end
        S_ISSUE_MUL: r_state <= S_WAIT_MUL;
        S_WAIT_MUL: begin
          if (mul_done) begin
            r_acc <= mul_c;
            r_k   <= r_k - 1'b1;
            for (int i = N - 1; i > 0; i--) r_c[i] <= r_c[i-1];
            r_c[0]      <= '0;
            r_add_valid <= 1'b1;
            r_state     <= S_ISSUE_ADD;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_horner_sequencer.sv
// tb_horner_sequencer: directed checks of horner_sequencer against latency-stub arithmetic units.
module tb_horner_sequencer;
  logic        clk = 0;
  logic        rstn = 1;
  logic        fp = 0;
  logic        spur_add = 0;
  logic        spur_mul = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [15:0] coef [4];
  logic [15:0] xin = 0;
  logic        in_ready, out_valid, add_valid, mul_valid, add_done, mul_done;
  logic [15:0] yout, add_a, add_b, add_c, mul_a, mul_b, mul_c;
  logic [1:0]  a_pipe = '0;
  logic [2:0]  m_pipe = '0;
  logic        iv1 = 0;
  logic        or1 = 0;
  logic [15:0] coef1 [1];
  logic        ir1, ov1, av1, mv1, ad1;
  logic [15:0] y1, aa1, ab1, ac1, ma1, mb1;
  logic [1:0]  a_pipe1 = '0;
  int          n_add1 = 0;
  int          n_mul1 = 0;
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  horner_sequencer #(.BITS(16), .PRECISION("HALF"), .N(4)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .coef_in(coef), .xin(xin), .out_valid(out_valid), .out_ready(out_ready),
    .yout(yout), .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_c(add_c), .mul_valid(mul_valid), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c)
  );
  horner_sequencer #(.BITS(16), .PRECISION("HALF"), .N(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .in_valid(iv1), .in_ready(ir1),
    .coef_in(coef1), .xin(16'd5), .out_valid(ov1), .out_ready(or1),
    .yout(y1), .add_valid(av1), .add_a(aa1), .add_b(ab1),
    .add_done(ad1), .add_c(ac1), .mul_valid(mv1), .mul_a(ma1),
    .mul_b(mb1), .mul_done(1'b0), .mul_c(16'd0)
  );
  // Half-precision helpers, exact only for small non-negative integer values.
  function automatic int h2i(logic [15:0] h);
    if (h[14:0] == 0) return 0;
    return int'({1'b1, h[9:0]}) >> (25 - int'(h[14:10]));
  endfunction
  function automatic logic [15:0] i2h(int v);
    int p;
    int m;
    if (v == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 11; i++) if (v[i]) p = i;
    m = (v << (10 - p)) & 32'h3FF;
    return {1'b0, 5'(15 + p), 10'(m)};
  endfunction
  // Stub units: add latency 2, multiply latency 3, done pulse one cycle.
  always @(posedge clk) begin
    a_pipe  <= {a_pipe[0], add_valid};
    m_pipe  <= {m_pipe[1:0], mul_valid};
    a_pipe1 <= {a_pipe1[0], av1};
    if (av1) n_add1 <= n_add1 + 1;
    if (mv1) n_mul1 <= n_mul1 + 1;
  end
  assign add_done = a_pipe[1] | spur_add;
  assign mul_done = m_pipe[2] | spur_mul;
  assign add_c = fp ? i2h(h2i(add_a) + h2i(add_b)) : add_a + add_b;
  assign mul_c = fp ? i2h(h2i(mul_a) * h2i(mul_b)) : 16'(mul_a * mul_b);
  assign ad1 = a_pipe1[1];
  assign ac1 = aa1 + ab1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic accept();
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  initial begin
    int lat;
    int t;
    logic ok;
    logic seen;
    coef = '{16'd1, 16'd2, 16'd3, 16'd4};
    coef1 = '{16'd7};
    #2 rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_yout", 32'(yout), 0);
    chk("rst_add_valid", 32'(add_valid), 0);
    chk("rst_mul_valid", 32'(mul_valid), 0);
    chk("rst_add_a", 32'(add_a), 0);
    @(negedge clk) rstn = 1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    // Integer evaluation: c={1,2,3,4}, x=2 -> 49 after 24 edges
    xin = 16'd2;
    accept();
    chk("busy_in_ready", 32'(in_ready), 0);
    wait_out(lat);
    chk("int_latency", 32'(lat), 24);
    chk("int_yout", 32'(yout), 32'h31);
    // Hold result while a new request waits
    coef = '{16'd3, 16'd0, 16'd0, 16'd1};
    xin = 16'd3;
    in_valid = 1;
    ok = 1;
    repeat (10) begin
      @(posedge clk); #1;
      ok &= (out_valid === 1'b1) && (yout === 16'h31) && (in_ready === 1'b0);
    end
    chk("hold_stable", 32'(ok), 1);
    // Spurious done pulses in OUT
    spur_add = 1; spur_mul = 1;
    @(posedge clk); #1;
    spur_add = 0; spur_mul = 0;
    @(posedge clk); #1;
    chk("spur_out_valid", 32'(out_valid), 1);
    chk("spur_out_yout", 32'(yout), 32'h31);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("release_in_ready", 32'(in_ready), 1);
    chk("release_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("second_accept", 32'(in_ready), 0);
    chk("second_add_valid", 32'(add_valid), 1);
    chk("second_add_a", 32'(add_a), 1);
    chk("second_add_b", 32'(add_b), 0);
    wait_out(lat);
    chk("second_yout", 32'(yout), 32'd30);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(posedge clk); #1;
    // Spurious done pulses in IDLE
    spur_add = 1; spur_mul = 1;
    @(posedge clk); #1;
    spur_add = 0; spur_mul = 0;
    @(posedge clk); #1;
    chk("spur_idle_in_ready", 32'(in_ready), 1);
    chk("spur_idle_issue", 32'({add_valid, mul_valid, out_valid}), 0);
    chk("spur_idle_yout", 32'(yout), 32'd30);
    // Reset while waiting on a multiply
    coef = '{16'd1, 16'd2, 16'd3, 16'd4};
    xin = 16'd2;
    accept();
    t = 0;
    while (mul_valid !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("reach_issue_mul", 32'(mul_valid), 1);
    @(posedge clk); #1;
    rstn = 0;
    #1;
    chk("abort_in_ready_low", 32'(in_ready), 0);
    @(negedge clk) rstn = 1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      seen |= out_valid | add_valid | mul_valid;
    end
    chk("abort_no_activity", 32'(seen), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    // Half-precision: all coefficients 1.0, x=1.0 -> 4.0
    fp = 1;
    coef = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    xin = 16'h3C00;
    accept();
    wait_out(lat);
    chk("fp_yout", 32'(yout), 32'h4400);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    fp = 0;
    // Single-coefficient instance
    t = n_add1;
    lat = n_mul1;
    iv1 = 1;
    @(posedge clk); #1;
    iv1 = 0;
    begin
      int l1;
      l1 = 0;
      while (ov1 !== 1'b1 && l1 < 100) begin
        @(posedge clk); #1;
        l1++;
      end
      chk("n1_latency", 32'(l1), 3);
    end
    chk("n1_yout", 32'(y1), 7);
    chk("n1_add_pulses", 32'(n_add1 - t), 1);
    chk("n1_mul_pulses", 32'(n_mul1 - lat), 0);
    or1 = 1;
    @(posedge clk); #1;
    or1 = 0;
    chk("n1_release", 32'({ir1, ov1}), 32'b10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
